// File: rtl/n_way_arbitrated_mux.sv
// n_way_arbitrated_mux: registered N-input mux with fixed-select or round-robin valid/ready arbitration
module n_way_arbitrated_mux #(
  parameter int BITS = 32,
  parameter int INPUTS = 16,
  localparam int SEL_W = $clog2(INPUTS)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [INPUTS-1:0][BITS-1:0]   DATA,
  input  logic [INPUTS-1:0]             VALID,
  output logic [INPUTS-1:0]             READY,
  input  logic                          MODE,
  input  logic [SEL_W-1:0]              SELECT,
  output logic [BITS-1:0]               OUT,
  output logic                          OUT_VALID,
  output logic [SEL_W-1:0]              OUT_SELECT,
  input  logic                          OUT_READY
);
  logic [SEL_W-1:0] ptr, rr_off, rr_idx, rr_nxt, cand;
  logic [INPUTS-1:0] rot;
  logic [SEL_W:0] sum;
  logic rr_hit, fx_hit, cand_hit, load, grant;
  // rotate VALID so bit 0 is PTR, take the first set bit and map it back to a channel index
  always_comb begin
    rot = INPUTS'({VALID, VALID} >> ptr);
    rr_off = '0;
    for (int j = INPUTS - 1; j >= 0; j--) if (rot[j]) rr_off = SEL_W'(j);
    sum = {1'b0, ptr} + {1'b0, rr_off};
    rr_idx = sum >= (SEL_W+1)'(INPUTS) ? SEL_W'(sum - (SEL_W+1)'(INPUTS)) : sum[SEL_W-1:0];
    rr_nxt = rr_idx == SEL_W'(INPUTS - 1) ? '0 : rr_idx + 1'b1;
  end
  assign rr_hit = |VALID;
  assign fx_hit = ({1'b0, SELECT} < (SEL_W+1)'(INPUTS)) && VALID[SELECT];
  assign cand_hit = MODE ? rr_hit : fx_hit;
  assign cand = MODE ? rr_idx : SELECT;
  assign load = !OUT_VALID || OUT_READY;
  assign grant = load && cand_hit && !RESET;
  assign READY = grant ? INPUTS'(1) << cand : '0;
  // one-entry output register; the pointer only advances on round-robin transfers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT <= '0;
      OUT_SELECT <= '0;
      OUT_VALID <= 1'b0;
      ptr <= '0;
    end else if (load) begin
      OUT_VALID <= cand_hit;
      if (cand_hit) begin
        OUT <= DATA[cand];
        OUT_SELECT <= cand;
        if (MODE) ptr <= rr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_n_way_arbitrated_mux.sv
// tb_n_way_arbitrated_mux: vector table, directed corner sequences and randomized model check
module tb_n_way_arbitrated_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst5, mode5, ordy5, ov5;
  logic [4:0][31:0] data5;
  logic [4:0] valid5, ready5;
  logic [2:0] sel5, osel5;
  logic [31:0] out5;

  logic rst16, ov16;
  logic [15:0][31:0] data16;
  logic [15:0] valid16, ready16;
  logic [3:0] sel16, osel16;
  logic [31:0] out16;

  n_way_arbitrated_mux #(.BITS(32), .INPUTS(5)) dut5 (
    .CLK(clk), .RESET(rst5), .DATA(data5), .VALID(valid5), .READY(ready5),
    .MODE(mode5), .SELECT(sel5), .OUT(out5), .OUT_VALID(ov5),
    .OUT_SELECT(osel5), .OUT_READY(ordy5));

  n_way_arbitrated_mux #(.BITS(32), .INPUTS(16)) dut16 (
    .CLK(clk), .RESET(rst16), .DATA(data16), .VALID(valid16), .READY(ready16),
    .MODE(1'b0), .SELECT(sel16), .OUT(out16), .OUT_VALID(ov16),
    .OUT_SELECT(osel16), .OUT_READY(1'b1));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference state of the 5-input instance, kept as plain integers
  int m_ptr = 0;
  int m_sel = 0;
  logic m_ov = 1'b0;
  logic [31:0] m_out = '0;

  task automatic tick5();
    int c;
    logic ld;
    logic [4:0] er;
    #1;
    ld = !m_ov || ordy5;
    c = -1;
    if (mode5) begin
      for (int j = 0; j < 5; j++) if (c < 0 && valid5[(m_ptr + j) % 5]) c = (m_ptr + j) % 5;
    end else if (sel5 < 3'd5 && valid5[sel5]) c = int'(sel5);
    er = (!rst5 && ld && c >= 0) ? 5'(1 << c) : 5'd0;
    chk("ready5", 32'(ready5), 32'(er));
    @(posedge clk);
    if (rst5) begin
      m_ov = 1'b0; m_out = '0; m_sel = 0; m_ptr = 0;
    end else if (ld) begin
      m_ov = c >= 0;
      if (c >= 0) begin
        m_out = data5[c];
        m_sel = c;
        if (mode5) m_ptr = (c + 1) % 5;
      end
    end
    #1;
    chk("out_valid5", 32'(ov5), 32'(m_ov));
    if (m_ov) begin
      chk("out5", out5, m_out);
      chk("out_select5", 32'(osel5), 32'(m_sel));
    end
  endtask

  typedef struct {
    logic [3:0] sel;
    logic [15:0] valid;
    logic [15:0] ready;
    logic ov;
    logic [3:0] osel;
    logic [31:0] out;
  } vec_t;
  vec_t vt[18];

  initial begin
    for (int i = 0; i < 16; i++)
      vt[i] = '{sel: 4'(15 - i), valid: 16'hffff, ready: 16'(1 << (15 - i)), ov: 1'b1,
                osel: 4'(15 - i), out: 32'((15 - i) * 32'h1111)};
    vt[16] = '{sel: 4'd7, valid: 16'hffff, ready: 16'h0080, ov: 1'b1, osel: 4'd7, out: 32'h7777};
    vt[17] = '{sel: 4'd5, valid: 16'hffdf, ready: 16'h0000, ov: 1'b0, osel: 4'd7, out: 32'h7777};
    for (int i = 0; i < 16; i++) data16[i] = 32'(i * 32'h1111);
    for (int i = 0; i < 5; i++) data5[i] = 32'hd00 + 32'(i);
    rst16 = 1'b1; valid16 = '1; sel16 = '0;
    rst5 = 1'b1; valid5 = '1; ordy5 = 1'b1; mode5 = 1'b1; sel5 = '0;

    // reset held two cycles with all channels requesting
    tick5();
    tick5();
    chk("rst_ready5", 32'(ready5), 0);
    chk("rst_out_valid5", 32'(ov5), 0);
    chk("rst_out5", out5, 0);
    chk("rst_out_select5", 32'(osel5), 0);
    chk("rst_out_valid16", 32'(ov16), 0);
    chk("rst_out16", out16, 0);
    rst16 = 1'b0;

    // fixed-select sweep on the 16-input instance
    for (int i = 0; i < 18; i++) begin
      sel16 = vt[i].sel;
      valid16 = vt[i].valid;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(ready16), 32'(vt[i].ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(ov16), 32'(vt[i].ov));
      chk($sformatf("vec%0d_out_select", i), 32'(osel16), 32'(vt[i].osel));
      chk($sformatf("vec%0d_out", i), out16, vt[i].out);
    end

    // round-robin wrap over five channels, first grant after release is 0
    rst5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick5();
      chk("rr_wrap_select", 32'(osel5), 32'(i % 5));
    end
    tick5();
    chk("rr_to_ptr3", 32'(osel5), 2);
    valid5 = 5'b00101;
    for (int i = 0; i < 4; i++) begin
      tick5();
      chk("rr_sparse_select", 32'(osel5), (i % 2) ? 2 : 0);
    end

    // back-pressure while holding channel 3
    mode5 = 1'b0; sel5 = 3'd3; valid5 = '1;
    tick5();
    chk("bp_load3", 32'(osel5), 3);
    ordy5 = 1'b0; mode5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid5 = 5'($urandom);
      tick5();
      chk("bp_ready", 32'(ready5), 0);
      chk("bp_hold_select", 32'(osel5), 3);
      chk("bp_hold_out", out5, 32'hd03);
    end
    ordy5 = 1'b1; valid5 = 5'b10001;
    tick5();
    chk("bp_refill_select", 32'(osel5), 4);
    chk("bp_refill_valid", 32'(ov5), 1);

    // out-of-range select never grants, mode switch during stall, fixed grants keep PTR
    mode5 = 1'b0; sel5 = 3'd7; valid5 = '1;
    for (int i = 0; i < 3; i++) begin
      tick5();
      chk("oor_ready", 32'(ready5), 0);
      chk("oor_out_valid", 32'(ov5), 0);
    end
    sel5 = 3'd1;
    tick5();
    ordy5 = 1'b0; mode5 = 1'b1;
    tick5();
    chk("mode_switch_hold", out5, 32'hd01);
    mode5 = 1'b0; sel5 = 3'd2; ordy5 = 1'b1;
    tick5();
    tick5();
    chk("fixed2_select", 32'(osel5), 2);
    mode5 = 1'b1;
    tick5();
    chk("ptr_kept_by_fixed", 32'(osel5), 0);

    // mid-operation reset with PTR at 3
    tick5();
    tick5();
    rst5 = 1'b1;
    tick5();
    chk("midrst_out_valid", 32'(ov5), 0);
    chk("midrst_out", out5, 0);
    rst5 = 1'b0; valid5 = 5'b11010;
    tick5();
    chk("midrst_first_grant", 32'(osel5), 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 5; k++) data5[k] = $urandom;
      valid5 = 5'($urandom);
      mode5 = 1'($urandom);
      sel5 = 3'($urandom_range(0, 7));
      ordy5 = $urandom_range(0, 3) != 0;
      rst5 = $urandom_range(0, 49) == 0;
      tick5();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
